// File: rtl/cpu_run_sequencer.sv
// Host-side run controller for the CPU core: loads two operands into data memory,
// pulses Start, waits for Ack (with timeout), reads the result back and offers it valid/ready.
module cpu_run_sequencer #(
  parameter logic [7:0]  OPA_ADDR     = 8'd0,
  parameter logic [7:0]  OPB_ADDR     = 8'd1,
  parameter logic [7:0]  RESULT_ADDR  = 8'd2,
  parameter int unsigned START_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       JobValid,
  output logic       JobReady,
  input  logic [7:0] OpA,
  input  logic [7:0] OpB,
  output logic       DmWrEn,
  output logic [7:0] DmAddr,
  output logic [7:0] DmWrData,
  input  logic [7:0] DmRdData,
  output logic       Start,
  input  logic       Ack,
  output logic       ResValid,
  output logic [7:0] Result,
  output logic       TimedOut,
  input  logic       ResReady,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_START, S_WAIT_ACK, S_RD_ISSUE, S_RD_CAPT, S_OUT
  } state_t;

  localparam logic [3:0]  START_LOAD = 4'(START_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_op_a, r_op_b, w_op_a_nxt, w_op_b_nxt;
  logic [3:0]  r_start_cnt, w_start_cnt_nxt;
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [7:0]  r_result, w_result_nxt;
  logic        r_timed_out, w_timed_out_nxt;
  logic        r_dm_wr_en, w_dm_wr_en;
  logic [7:0]  r_dm_addr, w_dm_addr;
  logic [7:0]  r_dm_wr_data, w_dm_wr_data;
  logic        r_start, w_start;
  logic        r_res_valid, w_res_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_start_cnt  <= '0;
      r_wait_cnt   <= '0;
      r_result     <= '0;
      r_timed_out  <= 1'b0;
      r_dm_wr_en   <= 1'b0;
      r_dm_addr    <= '0;
      r_dm_wr_data <= '0;
      r_start      <= 1'b0;
      r_res_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op_a       <= w_op_a_nxt;
      r_op_b       <= w_op_b_nxt;
      r_start_cnt  <= w_start_cnt_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_result     <= w_result_nxt;
      r_timed_out  <= w_timed_out_nxt;
      r_dm_wr_en   <= w_dm_wr_en;
      r_dm_addr    <= w_dm_addr;
      r_dm_wr_data <= w_dm_wr_data;
      r_start      <= w_start;
      r_res_valid  <= w_res_valid;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_a_nxt      = r_op_a;
    w_op_b_nxt      = r_op_b;
    w_start_cnt_nxt = r_start_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_result_nxt    = r_result;
    w_timed_out_nxt = r_timed_out;
    case (r_state)
      S_IDLE: begin
        if (JobValid) begin
          w_op_a_nxt  = OpA;
          w_op_b_nxt  = OpB;
          w_state_nxt = S_WR_A;
        end
      end
      S_WR_A: w_state_nxt = S_WR_B;
      S_WR_B: begin
        w_start_cnt_nxt = START_LOAD;
        w_state_nxt     = S_START;
      end
      S_START: begin
        if (r_start_cnt == 4'd0) begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = S_WAIT_ACK;
        end else begin
          w_start_cnt_nxt = r_start_cnt - 4'd1;
        end
      end
      S_WAIT_ACK: begin
        // Ack wins over an expiring timeout in the same cycle
        if (Ack) begin
          w_state_nxt = S_RD_ISSUE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_result_nxt    = '0;
          w_timed_out_nxt = 1'b1;
          w_state_nxt     = S_OUT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      S_RD_ISSUE: w_state_nxt = S_RD_CAPT;
      S_RD_CAPT: begin
        w_result_nxt    = DmRdData;
        w_timed_out_nxt = 1'b0;
        w_state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (ResReady) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with the state they belong to
  always_comb begin
    w_dm_wr_en   = 1'b0;
    w_dm_addr    = '0;
    w_dm_wr_data = '0;
    w_start      = 1'b0;
    w_res_valid  = 1'b0;
    case (w_state_nxt)
      S_WR_A: begin
        w_dm_wr_en   = 1'b1;
        w_dm_addr    = OPA_ADDR;
        w_dm_wr_data = w_op_a_nxt;
      end
      S_WR_B: begin
        w_dm_wr_en   = 1'b1;
        w_dm_addr    = OPB_ADDR;
        w_dm_wr_data = w_op_b_nxt;
      end
      S_START:    w_start     = 1'b1;
      S_RD_ISSUE: w_dm_addr   = RESULT_ADDR;
      S_OUT:      w_res_valid = 1'b1;
      default: ;
    endcase
  end

  assign JobReady = (r_state == S_IDLE);
  assign Busy     = (r_state != S_IDLE);
  assign DmWrEn   = r_dm_wr_en;
  assign DmAddr   = r_dm_addr;
  assign DmWrData = r_dm_wr_data;
  assign Start    = r_start;
  assign ResValid = r_res_valid;
  assign Result   = r_result;
  assign TimedOut = r_timed_out;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: default instance for normal runs, a second
// instance with a short timeout for the hung-program case.
module tb_cpu_run_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       JobValid = 1'b0, JobReady;
  logic [7:0] OpA = '0, OpB = '0;
  logic       DmWrEn;
  logic [7:0] DmAddr, DmWrData, DmRdData;
  logic       Start, Ack = 1'b0, ResValid, TimedOut, ResReady = 1'b0, Busy;
  logic [7:0] Result;

  logic       t_job_valid = 1'b0, t_job_ready, t_dm_wr_en, t_start, t_res_valid, t_timed_out;
  logic       t_res_ready = 1'b0, t_busy;
  logic [7:0] t_dm_addr, t_dm_wr_data, t_result;
  logic       t_saw_read = 1'b0;

  logic [7:0] dm [0:255];
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_wd = '0;
  int         wr_count = 0;
  int         n_cmp = 0, n_err = 0;

  always #5 Clk = ~Clk;

  cpu_run_sequencer dut (
    .Clk(Clk), .Reset(Reset), .JobValid(JobValid), .JobReady(JobReady),
    .OpA(OpA), .OpB(OpB), .DmWrEn(DmWrEn), .DmAddr(DmAddr), .DmWrData(DmWrData),
    .DmRdData(DmRdData), .Start(Start), .Ack(Ack), .ResValid(ResValid),
    .Result(Result), .TimedOut(TimedOut), .ResReady(ResReady), .Busy(Busy)
  );

  cpu_run_sequencer #(.TIMEOUT(16)) dut_to (
    .Clk(Clk), .Reset(Reset), .JobValid(t_job_valid), .JobReady(t_job_ready),
    .OpA(8'h21), .OpB(8'h42), .DmWrEn(t_dm_wr_en), .DmAddr(t_dm_addr),
    .DmWrData(t_dm_wr_data), .DmRdData(8'h5A), .Start(t_start), .Ack(1'b0),
    .ResValid(t_res_valid), .Result(t_result), .TimedOut(t_timed_out),
    .ResReady(t_res_ready), .Busy(t_busy)
  );

  always @(posedge Clk) begin
    if (cpu_we) dm[2] <= cpu_wd;
    if (DmWrEn) begin
      dm[DmAddr] <= DmWrData;
      wr_count   <= wr_count + 1;
    end
    DmRdData <= dm[DmAddr];
    if (!Reset && t_dm_addr == 8'd2) t_saw_read <= 1'b1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From the first START cycle, run until Start drops; returns Start length
  task automatic run_start(output int n);
    n = 0;
    while (Start === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  // CPU model: deposit a result and raise Ack for one sampled edge
  task automatic cpu_done(input logic [7:0] res);
    cpu_we = 1'b1;
    cpu_wd = res;
    Ack    = 1'b1;
    tick();
    cpu_we = 1'b0;
    Ack    = 1'b0;
  endtask

  initial begin
    int n;
    logic stable;

    // reset state
    tick(); tick();
    Reset = 1'b0;
    chk("rst_jobready", JobReady, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_start", Start, 0);
    chk("rst_dmwren", DmWrEn, 0);
    chk("rst_dmaddr", DmAddr, 0);
    chk("rst_dmwrdata", DmWrData, 0);
    chk("rst_resvalid", ResValid, 0);
    chk("rst_result", Result, 0);
    chk("rst_timedout", TimedOut, 0);

    // basic run
    JobValid = 1'b1; OpA = 8'd1; OpB = 8'd17;
    tick();
    JobValid = 1'b0;
    chk("wra_en", DmWrEn, 1);
    chk("wra_addr", DmAddr, 0);
    chk("wra_data", DmWrData, 1);
    chk("wra_busy", Busy, 1);
    chk("wra_jobready", JobReady, 0);
    tick();
    chk("wrb_en", DmWrEn, 1);
    chk("wrb_addr", DmAddr, 1);
    chk("wrb_data", DmWrData, 17);
    tick();
    chk("start_rise", Start, 1);
    chk("start_dmwren", DmWrEn, 0);
    run_start(n);
    chk("start_len", n, 4);
    chk("dm0", dm[0], 1);
    chk("dm1", dm[1], 17);
    repeat (19) tick();
    chk("wait_noresvalid", ResValid, 0);
    cpu_done(8'h01);
    chk("rdissue_addr", DmAddr, 2);
    chk("rdissue_wren", DmWrEn, 0);
    tick();
    chk("rdcapt_resvalid", ResValid, 0);
    tick();
    chk("out_resvalid", ResValid, 1);
    chk("out_result", Result, 8'h01);
    chk("out_timedout", TimedOut, 0);
    ResReady = 1'b1;
    tick();
    ResReady = 1'b0;
    chk("hs_resvalid", ResValid, 0);
    chk("hs_jobready", JobReady, 1);

    // Ack during START ignored, JobValid during WAIT_ACK ignored, backpressure
    JobValid = 1'b1; OpA = 8'h10; OpB = 8'h20;
    tick();
    JobValid = 1'b0;
    tick(); tick();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk("ackstart_start2", Start, 1);
    tick(); tick();
    chk("ackstart_start4", Start, 1);
    tick();
    chk("ackstart_wait_start", Start, 0);
    chk("ackstart_wait_dmaddr", DmAddr, 0);
    JobValid = 1'b1; OpA = 8'd99;
    tick();
    JobValid = 1'b0;
    chk("jvwait_busy", Busy, 1);
    chk("jvwait_resvalid", ResValid, 0);
    cpu_done(8'hA5);
    tick(); tick();
    chk("bp_resvalid", ResValid, 1);
    chk("bp_result", Result, 8'hA5);
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (ResValid !== 1'b1 || Result !== 8'hA5 || TimedOut !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    ResReady = 1'b1;
    tick();
    ResReady = 1'b0;
    chk("bp_hs_resvalid", ResValid, 0);
    chk("bp_hs_busy", Busy, 0);
    repeat (3) tick();
    chk("single_job_busy", Busy, 0);
    chk("single_job_writes", wr_count, 4);
    chk("single_job_dm0", dm[0], 8'h10);

    // reset during 2nd Start cycle
    JobValid = 1'b1; OpA = 8'd7; OpB = 8'd8;
    tick();
    JobValid = 1'b0;
    tick(); tick(); tick();
    chk("rst1_start2", Start, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst1_start", Start, 0);
    chk("rst1_busy", Busy, 0);
    chk("rst1_jobready", JobReady, 1);

    // reset during WAIT_ACK
    JobValid = 1'b1;
    tick();
    JobValid = 1'b0;
    tick(); tick();
    run_start(n);
    chk("rst2_start_len", n, 4);
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst2_busy", Busy, 0);
    chk("rst2_jobready", JobReady, 1);
    chk("rst2_start", Start, 0);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    stable = 1'b1;
    repeat (4) begin
      tick();
      if (ResValid !== 1'b0 || Busy !== 1'b0) stable = 1'b0;
    end
    chk("rst2_idle_no_result", stable, 1);

    // back-to-back jobs
    JobValid = 1'b1; OpA = 8'd3; OpB = 8'd4; ResReady = 1'b1;
    tick();
    OpA = 8'd5; OpB = 8'd6;
    chk("b2b1_wra", DmWrData, 3);
    tick();
    chk("b2b1_wrb", DmWrData, 4);
    tick();
    run_start(n);
    cpu_done(8'd7);
    tick(); tick();
    chk("b2b1_resvalid", ResValid, 1);
    chk("b2b1_result", Result, 7);
    tick();
    chk("b2b_idle_jobready", JobReady, 1);
    chk("b2b_idle_resvalid", ResValid, 0);
    tick();
    JobValid = 1'b0;
    chk("b2b2_wra_en", DmWrEn, 1);
    chk("b2b2_wra_data", DmWrData, 5);
    tick();
    chk("b2b2_wrb_data", DmWrData, 6);
    tick();
    run_start(n);
    cpu_done(8'd11);
    tick(); tick();
    chk("b2b2_resvalid", ResValid, 1);
    chk("b2b2_result", Result, 11);
    tick();
    ResReady = 1'b0;
    chk("b2b2_done", Busy, 0);

    // timeout on the short-timeout instance
    t_job_valid = 1'b1;
    tick();
    t_job_valid = 1'b0;
    tick(); tick();
    chk("to_start", t_start, 1);
    n = 0;
    while (t_start === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("to_start_len", n, 4);
    n = 0;
    while (t_res_valid !== 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_latency", n, 16);
    chk("to_result", t_result, 8'h00);
    chk("to_timedout", t_timed_out, 1);
    chk("to_no_read", t_saw_read, 0);
    t_res_ready = 1'b1;
    tick();
    t_res_ready = 1'b0;
    chk("to_hs_resvalid", t_res_valid, 0);
    chk("to_hs_jobready", t_job_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
